track_follower: RTL

Parametrised successor to the rover's line-following movement FSM. Filters the three IPS sensors (L, C active-low, R), classifies the track, and drives motors A/B through the PWM generator. Adds a programmable crossroad route, an enable, lost-line detection, and status outputs. Sits between the IPS sensor inputs and the PWM generator in the drive system.

---
 rtl/track_pkg.sv | 50 +++++
 rtl/sensor_debounce.sv | 41 ++++
 rtl/track_follower.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/track_pkg.sv
// Shared encodings for the track follower: FSM states, filtered track codes,
// motor drive codes and the state-to-drive mapping.
package track_pkg;

    typedef enum logic [3:0] {
        S_OFF   = 4'd0,
        S_ST    = 4'd1,
        S_CL    = 4'd2,
        S_L90   = 4'd3,
        S_CR    = 4'd4,
        S_R90   = 4'd5,
        S_CROSS = 4'd6,
        S_CST   = 4'd9,
        S_C90   = 4'd13,
        S_LOST  = 4'd15
    } state_t;

    // Track codes are the filtered {L, C, R}; C reads 0 when it sees the line.
    localparam logic [2:0] CODE_ST     = 3'b000;
    localparam logic [2:0] CODE_CR     = 3'b001;
    localparam logic [2:0] CODE_NONE   = 3'b010;
    localparam logic [2:0] CODE_R90    = 3'b011;
    localparam logic [2:0] CODE_CL     = 3'b100;
    localparam logic [2:0] CODE_CROSS  = 3'b101;
    localparam logic [2:0] CODE_L90    = 3'b110;
    localparam logic [2:0] CODE_CROSST = 3'b111;

    localparam logic [1:0] DRV_STOP   = 2'd0;
    localparam logic [1:0] DRV_FWD_LO = 2'd1;
    localparam logic [1:0] DRV_FWD_HI = 2'd2;
    localparam logic [1:0] DRV_REV    = 2'd3;

    // Returns {DriveA, DriveB}; CROSS never reaches here because it holds.
    function automatic logic [3:0] drive_of(input state_t s);
        logic [3:0] d;
        d = {DRV_STOP, DRV_STOP};
        case (s)
            S_ST:    d = {DRV_FWD_LO, DRV_FWD_LO};
            S_CL:    d = {DRV_FWD_LO, DRV_FWD_HI};
            S_L90:   d = {DRV_REV,    DRV_FWD_HI};
            S_CR:    d = {DRV_FWD_HI, DRV_FWD_LO};
            S_R90:   d = {DRV_FWD_HI, DRV_REV};
            S_CST:   d = {DRV_FWD_LO, DRV_FWD_LO};
            S_C90:   d = {DRV_FWD_HI, DRV_REV};
            default: d = {DRV_STOP, DRV_STOP};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Per-bit sensor filter: a bit's filtered value follows the raw value only
// after DEBOUNCE consecutive differing edges. DEBOUNCE=1 is a plain register.
module sensor_debounce
    import track_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] raw,
    output logic [2:0] filt
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bit
            logic [CNT_W-1:0] r_cnt;
            logic             r_filt;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_cnt  <= '0;
                    r_filt <= CODE_NONE[gi];
                end else if (raw[gi] == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_filt <= raw[gi];
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign filt[gi] = r_filt;
        end
    endgenerate

endmodule

// File: rtl/track_follower.sv
// Line-following movement FSM with crossroad route plan and lost-line timeout.
// Define TRACK_FOLLOWER_DEBOUNCE_EN to debounce the sensors; otherwise they are only registered.
module track_follower
    import track_pkg::*;
#(
    parameter int          DEBOUNCE     = 4,
    parameter int          CROSS_N      = 2,
    parameter logic [15:0] CROSS_PLAN   = 16'h0001,
    parameter int          LOST_TIMEOUT = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       L,
    input  logic       C,
    input  logic       R,
    output logic [1:0] DriveA,
    output logic [1:0] DriveB,
    output logic [3:0] State,
    output logic [3:0] CrossIdx,
    output logic       Lost
);

    localparam int LOST_W = $clog2(LOST_TIMEOUT + 1);
    localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_TIMEOUT - 1);
    localparam logic [3:0] CROSS_LAST = 4'(CROSS_N - 1);

`ifdef TRACK_FOLLOWER_DEBOUNCE_EN
    localparam int FILT_DEB = DEBOUNCE;
`else
    // Without the filter a single register stage is used whatever DEBOUNCE says.
    localparam int FILT_DEB = (DEBOUNCE >= 1) ? 1 : 1;
`endif

    logic [2:0]        w_code;
    state_t            r_state;
    state_t            w_normal;
    state_t            w_state_next;
    logic [LOST_W-1:0] r_lost_cnt;
    logic [LOST_W-1:0] w_lost_cnt_next;
    logic [3:0]        r_cross_idx;
    logic [3:0]        w_cross_idx_next;
    logic [1:0]        r_drive_a;
    logic [1:0]        r_drive_b;
    logic              r_lost;
    logic              w_count_cond;

    sensor_debounce #(
        .DEBOUNCE (FILT_DEB)
    ) u_debounce (
        .CLK  (CLK),
        .RST  (RST),
        .raw  ({L, C, R}),
        .filt (w_code)
    );

    always_comb begin
        w_normal = r_state;
        case (r_state)
            S_OFF: casez (w_code)
                3'b000:  w_normal = S_ST;
                3'b010:  w_normal = S_OFF;
                3'b0?1:  w_normal = S_CR;
                3'b1?0:  w_normal = S_CL;
                default: w_normal = S_CR;
            endcase
            S_ST: casez (w_code)
                3'b1?0:  w_normal = S_CL;
                3'b0?1:  w_normal = S_CR;
                3'b1?1:  w_normal = S_CROSS;
                default: w_normal = S_ST;
            endcase
            S_CL: casez (w_code)
                3'b00?:  w_normal = S_ST;
                3'b1?1:  w_normal = S_CROSS;
                3'b011:  w_normal = S_CROSS;
                3'b110:  w_normal = S_L90;
                default: w_normal = S_CL;
            endcase
            S_L90:   w_normal = w_code[1] ? S_L90 : S_CL;
            S_CR: casez (w_code)
                3'b?00:  w_normal = S_ST;
                3'b1?1:  w_normal = S_CROSS;
                3'b110:  w_normal = S_CROSS;
                3'b011:  w_normal = S_R90;
                default: w_normal = S_CR;
            endcase
            S_R90:   w_normal = w_code[1] ? S_R90 : S_CR;
            S_CROSS: w_normal = CROSS_PLAN[r_cross_idx] ? S_C90 : S_CST;
            S_CST:   w_normal = (w_code == CODE_ST) ? S_ST : S_CST;
            S_C90:   w_normal = w_code[1] ? S_R90 : S_C90;
            S_LOST:  w_normal = (w_code == CODE_NONE) ? S_LOST : S_OFF;
            default: w_normal = S_OFF;
        endcase
    end

    assign w_count_cond = ((r_state == S_ST) || (r_state == S_CL) || (r_state == S_CR))
                          && (w_code == CODE_NONE);

    always_comb begin
        w_state_next     = w_normal;
        w_lost_cnt_next  = '0;
        w_cross_idx_next = r_cross_idx;
        if (!EN) begin
            w_state_next = S_OFF;
        end else begin
            if (r_state == S_CROSS)
                w_cross_idx_next = (r_cross_idx == CROSS_LAST) ? 4'd0 : r_cross_idx + 4'd1;
            if (w_normal == S_CROSS) begin
                w_state_next = S_CROSS;
            end else if (w_count_cond && (r_lost_cnt == LOST_LAST)) begin
                w_state_next = S_LOST;
            end else if (w_count_cond) begin
                w_lost_cnt_next = r_lost_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_OFF;
            r_lost_cnt  <= '0;
            r_cross_idx <= 4'd0;
            r_drive_a   <= DRV_STOP;
            r_drive_b   <= DRV_STOP;
            r_lost      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_lost_cnt  <= w_lost_cnt_next;
            r_cross_idx <= w_cross_idx_next;
            r_lost      <= (w_state_next == S_LOST);
            // Drives are frozen for the single CROSS cycle.
            if (w_state_next != S_CROSS)
                {r_drive_a, r_drive_b} <= drive_of(w_state_next);
        end
    end

    assign State    = r_state;
    assign CrossIdx = r_cross_idx;
    assign DriveA   = r_drive_a;
    assign DriveB   = r_drive_b;
    assign Lost     = r_lost;

endmodule
